// File: rtl/cordic_multiplier_param.sv
// Iterative linear-mode CORDIC multiplier, one iteration per clock.
// Ports: clk, rst (async high), start; x (int), z (Q1.DATA_W-1) in; y, busy, done out.
module cordic_multiplier_param #(
  parameter int DATA_W      = 8,
  parameter int ITERS       = 8,
  parameter int FRAC_BITS   = 8,
  parameter int APPROX_LSBS = 0,
  localparam int ACC_W      = DATA_W + FRAC_BITS + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] z,
  output logic signed [ACC_W-1:0]  y,
  output logic                     busy,
  output logic                     done
);

  localparam int IT_W = $clog2(ITERS + 1);
  localparam int Z_W  = DATA_W + 1;
  localparam int K    = APPROX_LSBS;

  // Weight of z's MSB-1 in Zr units: 1.0 == 2^(DATA_W-1)
  localparam logic [Z_W-1:0] W0 = Z_W'(1) << (DATA_W - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IT_W-1:0]          iter;
  logic signed [DATA_W-1:0] xr;
  logic signed [Z_W-1:0]    zr;
  logic signed [ACC_W-1:0]  acc;

  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  s;
  logic signed [ACC_W-1:0]  b;
  logic signed [ACC_W-1:0]  sum;
  logic [Z_W-1:0]           w;
  logic signed [Z_W-1:0]    zr_nx;
  logic                     last;

  always_comb begin
    x_ext = ACC_W'(xr);
    s     = (x_ext <<< FRAC_BITS) >>> iter;
    w     = W0 >> iter;
    // Zr == 0 is treated as positive
    b     = zr[Z_W-1] ? -s : s;
    zr_nx = zr[Z_W-1] ? zr + $signed(w)
                      : zr - $signed(w);
    last  = (iter == IT_W'(ITERS - 1));
  end

  // Lower-part-OR adder: low K bits OR'd, no carry into upper part
  generate
    if (K == 0) begin : g_exact
      assign sum = acc + b;
    end else begin : g_loa
      assign sum[K-1:0] = acc[K-1:0] | b[K-1:0];
      assign sum[ACC_W-1:K] = acc[ACC_W-1:K]
                            + b[ACC_W-1:K];
    end
  endgenerate

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      iter  <= '0;
      xr    <= '0;
      zr    <= '0;
      acc   <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xr   <= x;
            zr   <= {z[DATA_W-1], z};
            acc  <= '0;
            iter <= '0;
          end
        end
        RUN: begin
          acc  <= sum;
          zr   <= zr_nx;
          iter <= iter + IT_W'(1);
          if (last) begin
            y    <= sum;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_multiplier_param.sv
// Directed and model-checked bench for cordic_multiplier_param.
// Three instances share stimulus: APPROX_LSBS = 0, 4, 8.
module tb_cordic_multiplier_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic signed [7:0] x = '0;
  logic signed [7:0] z = '0;
  logic signed [17:0] y0, y4, y8;
  logic busy0, busy4, busy8;
  logic done0, done4, done8;

  int nvec = 0;
  int nbad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  cordic_multiplier_param #(.APPROX_LSBS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .x(x), .z(z),
    .y(y0), .busy(busy0), .done(done0));
  cordic_multiplier_param #(.APPROX_LSBS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .x(x), .z(z),
    .y(y4), .busy(busy4), .done(done4));
  cordic_multiplier_param #(.APPROX_LSBS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .x(x), .z(z),
    .y(y8), .busy(busy8), .done(done8));

  always @(negedge clk) if (done0 === 1'b1) done_cnt++;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] aadd(input logic [17:0] a,
                                       input logic [17:0] b,
                                       input int k);
    logic [17:0] m, t;
    m = 18'((1 << k) - 1);
    t = (a >> k) + (b >> k);
    return (t << k) | ((a | b) & m);
  endfunction

  function automatic int model(input int xi, input int zi,
                               input int k);
    logic [17:0] yv, bv;
    int zr, s;
    yv = '0;
    zr = zi;
    for (int i = 0; i < 8; i++) begin
      s = (xi * 256) >>> i;
      bv = 18'((zr >= 0) ? s : -s);
      zr = (zr >= 0) ? zr - (128 >> i) : zr + (128 >> i);
      yv = aadd(yv, bv, k);
    end
    return $signed(yv);
  endfunction

  task automatic run_op(input int xi, input int zi,
                        output int lat);
    @(negedge clk);
    x = 8'(xi);
    z = 8'(zi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy0), 1);
    lat = 0;
    while (done0 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, t1, t2, dc, xi, zi, ideal, err, ax;

    #1 rst = 1'b1;
    #1;
    chk("rst_y", 32'($signed(y0)), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(100, 64, lat);
    chk("lat_100x64", lat, 8);
    chk("y_100x64", $signed(y0), 13000);
    chk("busy_at_done", 32'(busy0), 0);
    @(negedge clk);
    chk("done_pulse_end", 32'(done0), 0);
    chk("y_held", $signed(y0), 13000);

    run_op(-128, -128, lat);
    chk("lat_m128", lat, 8);
    chk("y_m128xm128", $signed(y0), 32512);
    run_op(0, -77, lat);
    chk("y_zero_x", $signed(y0), 0);
    run_op(-100, 64, lat);
    chk("y_m100x64", $signed(y0), -13000);

    // start re-asserted at edges 3 and 5 must be ignored
    @(negedge clk);
    x = 8'(100); z = 8'(64); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done0 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      start = (lat == 2 || lat == 4);
      x = 8'(50); z = 8'(-100);
    end
    start = 1'b0;
    chk("lat_ignore", lat, 8);
    chk("y_ignore", $signed(y0), 13000);
    repeat (3) @(negedge clk);
    chk("idle_after_ignore", 32'(busy0), 0);

    // start held high: back-to-back results
    x = 8'(100); z = 8'(64); start = 1'b1;
    t1 = -1; t2 = -1;
    for (int n = 1; n <= 30 && t2 < 0; n++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
    end
    start = 1'b0;
    chk("b2b_first", t1, 9);
    chk("b2b_gap", t2 - t1, 9);
    chk("b2b_y", $signed(y0), 13000);

    // asynchronous reset mid-operation
    @(negedge clk);
    x = 8'(50); z = 8'(64); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_y", 32'($signed(y0)), 0);
    chk("mid_rst_busy", 32'(busy0), 0);
    chk("mid_rst_done", 32'(done0), 0);
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", done_cnt - dc, 0);
    run_op(50, 64, lat);
    chk("lat_after_rst", lat, 8);
    chk("y_after_rst", $signed(y0), 6500);

    for (int n = 0; n < 1000; n++) begin
      xi = int'($urandom_range(0, 255)) - 128;
      zi = int'($urandom_range(0, 255)) - 128;
      run_op(xi, zi, lat);
      chk("rand_lat", lat, 8);
      chk("rand_k0", $signed(y0), model(xi, zi, 0));
      chk("rand_k4", $signed(y4), model(xi, zi, 4));
      chk("rand_k8", $signed(y8), model(xi, zi, 8));
      ideal = xi * zi * 2;
      err = $signed(y0) - ideal;
      if (err < 0) err = -err;
      ax = (xi < 0) ? -xi : xi;
      chk("rand_bound", 32'(err <= 2 * ax), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
